fpu_exp_align_pipe: RTL

- Parametrised, pipelined exponent-alignment front end for the FPU add/sub datapath; successor to the single-width combinational exponent subtractor.
- Takes two biased exponents and computes the larger exponent, the absolute difference (mantissa right-shift amount), the swap flag and the equality flag.
- Two register stages with valid/ready handshake at both sides; sits between operand unpack and mantissa align-shift.

---
 rtl/fpu_exp_align_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/fpu_exp_align_pipe.sv
// Two-stage exponent alignment front end for the FPU add/sub path: max exponent, shift amount, swap/equal flags.
// Optional shift clamp to SHIFT_MAX is compiled in with FPU_EXP_SHIFT_SAT_EN.
module fpu_exp_align_pipe #(
  parameter int unsigned SIZE_EXP  = 8,
  parameter int unsigned SHIFT_MAX = 27,
  parameter int unsigned SIZE_TAG  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZE_EXP-1:0] i_exp_a,
  input  logic [SIZE_EXP-1:0] i_exp_b,
  input  logic [SIZE_TAG-1:0] i_tag,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_EXP-1:0] o_exp_max,
  output logic [SIZE_EXP-1:0] o_shift,
  output logic                o_swap,
  output logic                o_equal,
  output logic                o_shift_sat,
  output logic [SIZE_TAG-1:0] o_tag
);

  localparam int unsigned DW = SIZE_EXP + 1;

  if (SHIFT_MAX >= (64'd1 << SIZE_EXP)) begin : g_bad_shift_max
    $error("SHIFT_MAX must be below 2**SIZE_EXP");
  end

  logic                s1_valid, s2_valid;
  logic                s1_load, s2_load;
  logic [DW-1:0]       diff_ab, diff_ba;
  logic [DW-1:0]       s1_diff_ab, s1_diff_ba;
  logic [SIZE_EXP-1:0] s1_a, s1_b;
  logic [SIZE_TAG-1:0] s1_tag;

  logic                s1_borrow;
  logic [SIZE_EXP-1:0] shift_raw, shift_d, exp_max_d;
  logic                equal_d, sat_d;

  logic [SIZE_EXP-1:0] s2_exp_max, s2_shift;
  logic                s2_swap, s2_equal, s2_sat;
  logic [SIZE_TAG-1:0] s2_tag;

  assign s2_load = ~s2_valid | i_ready;
  assign s1_load = ~s1_valid | s2_load;
  assign o_ready = s1_load;

  assign diff_ab = {1'b0, i_exp_a} + {1'b0, ~i_exp_b} + DW'(1);
  assign diff_ba = {1'b0, i_exp_b} + {1'b0, ~i_exp_a} + DW'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_diff_ab <= '0;
      s1_diff_ba <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_tag     <= '0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_diff_ab <= diff_ab;
        s1_diff_ba <= diff_ba;
        s1_a       <= i_exp_a;
        s1_b       <= i_exp_b;
        s1_tag     <= i_tag;
      end
    end
  end

  // Carry-out of each difference is "minuend >= subtrahend"; both set means A == B.
  always_comb begin
    s1_borrow = ~s1_diff_ab[DW-1];
    exp_max_d = s1_borrow ? s1_b : s1_a;
    shift_raw = s1_borrow ? s1_diff_ba[SIZE_EXP-1:0] : s1_diff_ab[SIZE_EXP-1:0];
    equal_d   = s1_diff_ab[DW-1] & s1_diff_ba[DW-1];
`ifdef FPU_EXP_SHIFT_SAT_EN
    sat_d     = shift_raw > SIZE_EXP'(SHIFT_MAX);
    shift_d   = sat_d ? SIZE_EXP'(SHIFT_MAX) : shift_raw;
`else
    sat_d     = 1'b0;
    shift_d   = shift_raw;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid   <= 1'b0;
      s2_exp_max <= '0;
      s2_shift   <= '0;
      s2_swap    <= 1'b0;
      s2_equal   <= 1'b0;
      s2_sat     <= 1'b0;
      s2_tag     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_exp_max <= exp_max_d;
        s2_shift   <= shift_d;
        s2_swap    <= s1_borrow;
        s2_equal   <= equal_d;
        s2_sat     <= sat_d;
        s2_tag     <= s1_tag;
      end
    end
  end

  assign o_valid     = s2_valid;
  assign o_exp_max   = s2_exp_max;
  assign o_shift     = s2_shift;
  assign o_swap      = s2_swap;
  assign o_equal     = s2_equal;
  assign o_shift_sat = s2_sat;
  assign o_tag       = s2_tag;

endmodule
